led_blink: RTL and testbench
============================

Name: led_blink

Overview:
- Output-side counterpart of the key debounce/capture block: converts single-cycle event pulses (e.g. a debounced key capture) into human-visible LED blink sequences.
- Each request blinks the LED N times with fixed on/off periods in milliseconds.
- Provides busy/done status and a one-deep pending-request buffer, so events arriving mid-sequence are not lost.
- Sits between event sources (key capture, link status) and board LED pins.

Parameters:
- CLK_FREQ, 100000000: clk_i frequency in Hz.
- ON_MS, 100: LED-on time per blink, in ms, range 1..1000.
- OFF_MS, 100: LED-off time after each blink, in ms, range 1..1000.
- CNT_W, 4: width of the blink-count input.
- LED_ACTIVE_LOW, 1: 1 means led_o is driven 0 when lit; 0 means driven 1 when lit.

Ports:
- clk_i, input, 1: system clock.
- rstn_i, input, 1: asynchronous active-low reset.
- trig_i, input, 1: single-cycle request strobe, sampled on the rising edge of clk_i.
- num_i, input, CNT_W: blink count, valid on cycles where trig_i=1.
- busy_o, output, 1: high while a sequence is running.
- done_o, output, 1: single-cycle pulse when a request completes.
- led_o, output, 1: LED drive; polarity set by LED_ACTIVE_LOW.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, busy_o=0, done_o=0, led_o=inactive level (1 when LED_ACTIVE_LOW=1), pending buffer empty, all counters 0.
- Timing constants:
  - MS_CYC = CLK_FREQ/1000 cycles per ms.
  - ON_CYC = ON_MS*MS_CYC.
  - OFF_CYC = OFF_MS*MS_CYC.
  - The ms prescaler restarts at 0 on every phase entry, so phase lengths are exact.
- Internal state: FSM states IDLE, ON, OFF; a remaining-blink counter rem (CNT_W bits); a pending buffer (pend_v flag, pend_n value).
- IDLE:
  - trig_i=1 and num_i!=0: at that edge, rem<=num_i, state<=ON, busy_o<=1, led_o<=lit. Latency is 1 edge; the LED is lit in the cycle after the strobe.
  - trig_i=1 and num_i==0: ignored. No busy_o, no done_o.
- ON: after exactly ON_CYC cycles, led_o<=unlit, state<=OFF.
- OFF: after exactly OFF_CYC cycles, rem<=rem-1.
  - If rem>1: state<=ON, led_o<=lit.
  - If rem==1: the request is complete. done_o<=1 for exactly one cycle, then:
    - Same-edge trig_i with num_i!=0: start that request immediately (state<=ON, busy_o stays 1). Any pend entry is discarded; the newest request wins.
    - Else if pend_v: start pend_n (state<=ON), clear pend_v.
    - Else: state<=IDLE, busy_o<=0.
- Request during ON/OFF (except at the completion edge): trig_i with num_i!=0 sets pend_v<=1, pend_n<=num_i. A later trig overwrites pend_n (last wins, depth 1). num_i==0 is ignored.
- Each request occupies exactly N*(ON_CYC+OFF_CYC) cycles of busy_o. Chained requests keep busy_o high continuously.
- All outputs are registered; no combinational path from inputs to outputs.
- Counters do not wrap: the phase counter is cleared on every phase change.
- Reset mid-sequence: immediately returns to the reset values; the pending request is dropped.

Test Plan (CLK_FREQ=10000 so MS_CYC=10; ON_MS=2 so ON_CYC=20; OFF_MS=3 so OFF_CYC=30; LED_ACTIVE_LOW=1):
- Single blink: trig at edge k with num=1 -> led_o=0 for edges k..k+19, 1 from k+20; busy_o high for 50 cycles; done_o=1 exactly one cycle after edge k+50; busy_o=0 after.
- Three blinks: trig with num=3 -> three 20-cycle low pulses spaced 50 cycles apart; busy_o high for 150 cycles; a single done_o pulse.
- Zero count: trig with num=0 in IDLE -> busy_o, done_o and led_o unchanged for 200 cycles.
- Pending: num=2 started, then trig num=1 at cycle 30 and trig num=3 at cycle 60 -> after 100 cycles, done_o pulses and busy_o stays high; a 3-blink sequence (150 cycles) follows; total 2 done_o pulses; the num=1 request is never executed.
- Completion-edge collision: pend holds num=2, and trig num=1 arrives on the completion edge -> exactly one blink follows, pend is discarded, busy_o is continuous.
- Reset mid-ON: num=5 running, rstn_i=0 at cycle 10 -> led_o=1 and busy_o=0 asynchronously, without waiting for a clock edge; after release, no activity until a new trig.

Source files
------------

// File: rtl/led_blink_if.sv
// led_blink_if: request strobe/count in, busy/done/LED status out.
// master drives trig_i/num_i; slave (led_blink) drives busy_o/done_o/led_o.
interface led_blink_if #(
  parameter int CNT_W = 4
);
  logic             trig_i;
  logic [CNT_W-1:0] num_i;
  logic             busy_o;
  logic             done_o;
  logic             led_o;

  modport master (
    output trig_i,
    output num_i,
    input  busy_o,
    input  done_o,
    input  led_o
  );

  modport slave (
    input  trig_i,
    input  num_i,
    output busy_o,
    output done_o,
    output led_o
  );
endinterface

// File: rtl/led_blink.sv
// led_blink: turns request strobes into N timed LED blinks, 1-deep pending buffer.
// Ports: clk_i, rstn_i (async low), bus (trig_i/num_i in; busy_o/done_o/led_o out).
module led_blink #(
  parameter int CLK_FREQ       = 100000000,
  parameter int ON_MS          = 100,
  parameter int OFF_MS         = 100,
  parameter int CNT_W          = 4,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  led_blink_if.slave bus
);

  localparam int MS_CYC = CLK_FREQ / 1000;
  localparam int PRE_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int MS_W   = 10;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYC - 1);
  localparam logic [MS_W-1:0]  ON_LAST  = MS_W'(ON_MS - 1);
  localparam logic [MS_W-1:0]  OFF_LAST = MS_W'(OFF_MS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  localparam logic LED_UNLIT = LED_ACTIVE_LOW;
  localparam logic LED_LIT   = !LED_ACTIVE_LOW;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] pend_n_q, pend_n_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             led_q, led_d;

  logic             req;
  logic             ms_end;
  logic             ph_end;

  assign req    = bus.trig_i && (bus.num_i != '0);
  assign ms_end = (pre_q == PRE_LAST);
  assign ph_end = ms_end &&
                  (ms_q == ((state_q == S_ON) ? ON_LAST : OFF_LAST));

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    pend_v_d = pend_v_q;
    pend_n_d = pend_n_q;
    pre_d    = pre_q;
    ms_d     = ms_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    led_d    = led_q;

    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (req) begin
          state_d = S_ON;
          rem_d   = bus.num_i;
          busy_d  = 1'b1;
          led_d   = LED_LIT;
          pre_d   = '0;
          ms_d    = '0;
        end
      end

      (state_q == S_ON): begin
        if (ph_end) begin
          state_d = S_OFF;
          led_d   = LED_UNLIT;
          pre_d   = '0;
          ms_d    = '0;
        end else if (ms_end) begin
          pre_d = '0;
          ms_d  = ms_q + MS_W'(1);
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
        if (req) begin
          pend_v_d = 1'b1;
          pend_n_d = bus.num_i;
        end
      end

      (state_q == S_OFF): begin
        if (ph_end) begin
          pre_d = '0;
          ms_d  = '0;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q != CNT_W'(1)) begin
            state_d = S_ON;
            led_d   = LED_LIT;
            if (req) begin
              pend_v_d = 1'b1;
              pend_n_d = bus.num_i;
            end
          end else begin
            // Completion edge: a same-edge request beats the buffered one.
            done_d = 1'b1;
            if (req) begin
              state_d  = S_ON;
              rem_d    = bus.num_i;
              led_d    = LED_LIT;
              pend_v_d = 1'b0;
            end else if (pend_v_q) begin
              state_d  = S_ON;
              rem_d    = pend_n_q;
              led_d    = LED_LIT;
              pend_v_d = 1'b0;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end else begin
          if (ms_end) begin
            pre_d = '0;
            ms_d  = ms_q + MS_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
          if (req) begin
            pend_v_d = 1'b1;
            pend_n_d = bus.num_i;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        led_d   = LED_UNLIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      pend_v_q <= 1'b0;
      pend_n_q <= '0;
      pre_q    <= '0;
      ms_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      led_q    <= LED_UNLIT;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      pend_v_q <= pend_v_d;
      pend_n_q <= pend_n_d;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      led_q    <= led_d;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.led_o  = led_q;

endmodule

// File: tb/tb_led_blink.sv
// tb_led_blink: directed checks of led_blink with MS_CYC=10, ON_CYC=20, OFF_CYC=30.
// Each observation is {led_o, busy_o, done_o} taken 1 time unit after a clock edge.
module tb_led_blink;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  led_blink_if #(.CNT_W(4)) bus ();

  led_blink #(
    .CLK_FREQ      (10000),
    .ON_MS         (2),
    .OFF_MS        (3),
    .CNT_W         (4),
    .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe is sampled at the next edge; that edge is i=0 of each scenario.
  task automatic start(input logic [3:0] n);
    bus.trig_i = 1'b1;
    bus.num_i  = n;
    step();
    bus.trig_i = 1'b0;
    bus.num_i  = '0;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    bus.trig_i = 1'b0;
    bus.num_i  = '0;
    rstn = 1'b0;
    #22;
    got = {bus.led_o, bus.busy_o, bus.done_o};
    checks++;
    if (got !== 3'b100) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", got, 3'b100);
    end
    rstn = 1'b1;
    step();
    got = {bus.led_o, bus.busy_o, bus.done_o};
    checks++;
    if (got !== 3'b100) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", got, 3'b100);
    end
  endtask

  task automatic test_single();
    logic [2:0] got, exp;
    start(4'd1);
    for (int i = 0; i <= 60; i++) begin
      if (i > 0) step();
      exp = {(i >= 20), (i < 50), (i == 50)};
      got = {bus.led_o, bus.busy_o, bus.done_o};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL single i=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_three();
    logic [2:0] got, exp;
    start(4'd3);
    for (int i = 0; i <= 160; i++) begin
      if (i > 0) step();
      exp = {!((i < 150) && ((i % 50) < 20)), (i < 150), (i == 150)};
      got = {bus.led_o, bus.busy_o, bus.done_o};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL three i=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_zero();
    logic [2:0] got;
    start(4'd0);
    for (int i = 0; i < 200; i++) begin
      if (i > 0) step();
      got = {bus.led_o, bus.busy_o, bus.done_o};
      checks++;
      if (got !== 3'b100) begin
        failures++;
        $display("FAIL zero i=%0d got=%b exp=%b", i, got, 3'b100);
      end
    end
  endtask

  // num=2 running; num=1 then num=3 queued; only num=3 runs after.
  task automatic test_pending();
    logic [2:0] got, exp;
    int dones = 0;
    start(4'd2);
    for (int i = 0; i <= 270; i++) begin
      if (i > 0) begin
        if (i == 30) begin
          bus.trig_i = 1'b1;
          bus.num_i  = 4'd1;
        end
        if (i == 60) begin
          bus.trig_i = 1'b1;
          bus.num_i  = 4'd3;
        end
        step();
        bus.trig_i = 1'b0;
        bus.num_i  = '0;
      end
      exp = {!((i < 250) && ((i % 50) < 20)), (i < 250),
             (i == 100) || (i == 250)};
      got = {bus.led_o, bus.busy_o, bus.done_o};
      if (bus.done_o === 1'b1) dones++;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pending i=%0d got=%b exp=%b", i, got, exp);
      end
    end
    checks++;
    if (dones != 2) begin
      failures++;
      $display("FAIL pending_dones got=%0d exp=2", dones);
    end
  endtask

  // pend holds 2; a num=1 strobe on the completion edge wins.
  task automatic test_collision();
    logic [2:0] got, exp;
    start(4'd1);
    for (int i = 0; i <= 160; i++) begin
      if (i > 0) begin
        if (i == 10) begin
          bus.trig_i = 1'b1;
          bus.num_i  = 4'd2;
        end
        if (i == 50) begin
          bus.trig_i = 1'b1;
          bus.num_i  = 4'd1;
        end
        step();
        bus.trig_i = 1'b0;
        bus.num_i  = '0;
      end
      exp = {!((i < 100) && ((i % 50) < 20)), (i < 100),
             (i == 50) || (i == 100)};
      got = {bus.led_o, bus.busy_o, bus.done_o};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL collision i=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got;
    start(4'd5);
    repeat (10) step();
    got = {bus.led_o, bus.busy_o, bus.done_o};
    checks++;
    if (got !== 3'b010) begin
      failures++;
      $display("FAIL rst_mid_pre got=%b exp=%b", got, 3'b010);
    end
    #2;
    rstn = 1'b0;
    #1;
    got = {bus.led_o, bus.busy_o, bus.done_o};
    checks++;
    if (got !== 3'b100) begin
      failures++;
      $display("FAIL rst_mid_async got=%b exp=%b", got, 3'b100);
    end
    repeat (3) step();
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      got = {bus.led_o, bus.busy_o, bus.done_o};
      checks++;
      if (got !== 3'b100) begin
        failures++;
        $display("FAIL rst_mid_idle i=%0d got=%b exp=%b", i, got, 3'b100);
      end
    end
    start(4'd1);
    got = {bus.led_o, bus.busy_o, bus.done_o};
    checks++;
    if (got !== 3'b010) begin
      failures++;
      $display("FAIL rst_mid_restart got=%b exp=%b", got, 3'b010);
    end
    repeat (60) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_zero();
    test_pending();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
